// File: rtl/cic_up_sampler_if.sv
// ---------------------------------------------------------------------------
// cic_up_sampler_if : sample/strobe bundle for the CIC interpolator. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cic_up_sampler_if #(
  parameter int W = 10
);
  logic                eno;
  logic signed [W-1:0] in;
  logic                in_rdy;
  logic signed [W-1:0] out;

  modport master (output eno, output in, input in_rdy, input out);
  modport slave  (input eno, input in, output in_rdy, output out);
endinterface

`default_nettype wire

// File: rtl/cic_up_sampler.sv
// ---------------------------------------------------------------------------
// cic_up_sampler : N-stage CIC interpolator by R with unity-DC attenuator. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cic_up_sampler #(
  parameter int W = 10,
  parameter int R = 4,
  parameter int M = 1,
  parameter int N = 2
) (
  input  logic            clk,
  input  logic            rst,
  cic_up_sampler_if.slave bus
);

  localparam int GAIN   = ((R * M) ** N) / R;
  localparam int DW     = (GAIN <= 1) ? W : W + $clog2(GAIN);
  localparam int PW     = $clog2(R);
  localparam int ATTN_I = ((1 << (DW - 1)) + GAIN / 2) / GAIN;
  localparam logic signed [2*DW-1:0] ATTN = (2 * DW)'(ATTN_I);

  logic [PW-1:0]        r_ph;
  logic                 w_in_rdy;
  logic signed [DW-1:0] w_comb_in  [N];
  logic signed [DW-1:0] w_comb_out [N];
  logic signed [DW-1:0] w_integ_in [N];
  logic signed [DW-1:0] w_integ_out[N];
  logic signed [DW-1:0] r_z;
  logic signed [2*DW-1:0] w_prod;
  logic signed [W-1:0]  r_out;

  assign w_in_rdy    = bus.eno & (r_ph == '0);
  assign bus.in_rdy  = w_in_rdy;
  assign bus.out     = r_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph <= '0;
    end else if (bus.eno) begin
      r_ph <= (r_ph == PW'(R - 1)) ? '0 : r_ph + PW'(1);
    end
  end

  // Comb section runs at the low rate: it only advances on an accepted sample.
  generate
    for (genvar k = 0; k < N; k++) begin : g_comb
      logic signed [DW-1:0] r_c;
      logic signed [DW-1:0] r_d [M];

      if (k == 0) begin : g_first
        assign w_comb_in[k] = DW'(bus.in);
      end else begin : g_chain
        assign w_comb_in[k] = w_comb_out[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_c <= '0;
          for (int j = 0; j < M; j++) r_d[j] <= '0;
        end else if (w_in_rdy) begin
          r_c    <= w_comb_in[k] - r_d[M-1];
          r_d[0] <= w_comb_in[k];
          for (int j = 1; j < M; j++) r_d[j] <= r_d[j-1];
        end
      end

      assign w_comb_out[k] = r_c;
    end
  endgenerate

  // Zero-stuffing: the comb result is forwarded only in phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= '0;
    end else if (bus.eno) begin
      r_z <= (r_ph == '0) ? w_comb_out[N-1] : '0;
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_integ
      logic signed [DW-1:0] r_i;

      if (k == 0) begin : g_first
        assign w_integ_in[k] = r_z;
      end else begin : g_chain
        assign w_integ_in[k] = w_integ_out[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_i <= '0;
        end else if (bus.eno) begin
          r_i <= r_i + w_integ_in[k];
        end
      end

      assign w_integ_out[k] = r_i;
    end
  endgenerate

  // Q1.(DW-1) scaling back to unity DC gain; floor shift, wrap on truncation.
  assign w_prod = (2 * DW)'(w_integ_out[N-1]) * ATTN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (bus.eno) begin
      r_out <= W'(w_prod >>> (DW - 1));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cic_up_sampler.sv
// ---------------------------------------------------------------------------
// tb_cic_up_sampler : directed self-checking bench for cic_up_sampler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cic_up_sampler;

  localparam int W  = 10;
  localparam int NA = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  int imp_exp [7] = '{100, 200, 300, 400, 300, 200, 100};
  int h       [7] = '{1, 2, 3, 4, 3, 2, 1};

  cic_up_sampler_if #(.W(W)) bus ();

  cic_up_sampler #(.W(W), .R(4), .M(1), .N(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.eno = 1'b0;
    bus.in  = '0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.out !== 10'sd0) begin
      n_fail++; $display("FAIL reset_out: got %0d, expected 0", bus.out);
    end
    bus.eno = 1'b1;
    #1;
    n_checks++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_rdy: got %b, expected 1", bus.in_rdy);
    end
    bus.in = 10'sd300;
    repeat (14) tick();
    n_checks++;
    if (bus.out !== 10'sd225) begin
      n_fail++; $display("FAIL reset_prerun_out: got %0d, expected 225", bus.out);
    end
    n_checks++;
    if (bus.in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_prerun_in_rdy: got %b, expected 0", bus.in_rdy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out !== 10'sd0) begin
      n_fail++; $display("FAIL async_reset_out: got %0d, expected 0", bus.out);
    end
    n_checks++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_in_rdy: got %b, expected 1", bus.in_rdy);
    end
    bus.eno = 1'b0;
    #1;
    n_checks++;
    if (bus.in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_rdy_eno0: got %b, expected 0", bus.in_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_phase();
    logic expv;
    apply_reset();
    bus.eno = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      expv = (c % 4 == 0);
      n_checks++;
      if (bus.in_rdy !== expv) begin
        n_fail++; $display("FAIL phase_in_rdy c=%0d: got %b, expected %b", c, bus.in_rdy, expv);
      end
      tick();
    end
    tick();
    bus.eno = 1'b0;
    repeat (3) tick();
    bus.eno = 1'b1;
    #1;
    n_checks++;
    if (bus.in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL phase_hold: got %b, expected 0", bus.in_rdy);
    end
    repeat (3) tick();
    n_checks++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL phase_wrap: got %b, expected 1", bus.in_rdy);
    end
  endtask

  task automatic test_impulse(input bit skip_reset);
    int expv;
    if (!skip_reset) apply_reset();
    bus.eno = 1'b1;
    bus.in  = 10'sd400;
    #1;
    n_checks++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL impulse_accept: got %b, expected 1", bus.in_rdy);
    end
    tick();
    for (int k = 1; k <= 22; k++) begin
      bus.in = (k % 4 == 0) ? 10'sd0 : -10'sd77;
      tick();
      expv = (k >= 11 && k <= 17) ? imp_exp[k-11] : 0;
      n_checks++;
      if (bus.out !== W'(expv)) begin
        n_fail++; $display("FAIL impulse k=%0d: got %0d, expected %0d", k, bus.out, expv);
      end
    end
  endtask

  task automatic test_step(input int v);
    int lo, hi;
    lo = (v < 0) ? v : 0;
    hi = (v < 0) ? 0 : v;
    apply_reset();
    bus.eno = 1'b1;
    bus.in  = W'(v);
    for (int k = 0; k <= 30; k++) begin
      tick();
      n_checks++;
      if (bus.out < lo || bus.out > hi) begin
        n_fail++; $display("FAIL step_range v=%0d k=%0d: got %0d, expected %0d..%0d", v, k, bus.out, lo, hi);
      end
      if (k >= 14) begin
        n_checks++;
        if (bus.out !== W'(v)) begin
          n_fail++; $display("FAIL step_settle v=%0d k=%0d: got %0d, expected %0d", v, k, bus.out, v);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int k, expv;
    logic en;
    logic signed [W-1:0] prev;
    apply_reset();
    bus.in = 10'sd400;
    k      = -1;
    prev   = '0;
    for (int c = 0; c < 600 && k < 22; c++) begin
      bus.eno = ($urandom_range(99, 0) < 30);
      en      = bus.eno;
      tick();
      if (en) begin
        k++;
        if (k >= 1) begin
          expv = (k >= 11 && k <= 17) ? imp_exp[k-11] : 0;
          n_checks++;
          if (bus.out !== W'(expv)) begin
            n_fail++; $display("FAIL gaps k=%0d: got %0d, expected %0d", k, bus.out, expv);
          end
        end
        bus.in = ((k + 1) % 4 == 0) ? 10'sd0 : -10'sd77;
      end else begin
        n_checks++;
        if (bus.out !== prev || bus.in_rdy !== 1'b0) begin
          n_fail++; $display("FAIL gaps_hold: got out=%0d in_rdy=%b, expected out=%0d in_rdy=0", bus.out, bus.in_rdy, prev);
        end
      end
      prev = bus.out;
    end
    bus.eno = 1'b0;
    n_checks++;
    if (k < 22) begin
      n_fail++; $display("FAIL gaps_timeout: got %0d strobes, expected 22", k);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.eno = 1'b1;
    bus.in  = 10'sd400;
    tick();
    for (int k = 1; k <= 13; k++) begin
      bus.in = (k % 4 == 0) ? 10'sd0 : -10'sd77;
      tick();
    end
    n_checks++;
    if (bus.out !== 10'sd300) begin
      n_fail++; $display("FAIL midimpulse_out: got %0d, expected 300", bus.out);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out !== 10'sd0 || bus.in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL midimpulse_reset: got out=%0d in_rdy=%b, expected out=0 in_rdy=1", bus.out, bus.in_rdy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out !== 10'sd0) begin
      n_fail++; $display("FAIL reset_held_out: got %0d, expected 0", bus.out);
    end
    rst = 1'b0;
    test_impulse(1'b1);
  endtask

  task automatic test_full_scale();
    int  xs [NA];
    int  acc, t;
    real expr, err;
    apply_reset();
    bus.eno = 1'b1;
    for (int k = 0; k < 4 * NA + 20; k++) begin
      if (k % 4 == 0 && k / 4 < NA) begin
        xs[k/4] = ((k / 4) % 2 == 0) ? 511 : -512;
        bus.in  = W'(xs[k/4]);
      end else begin
        bus.in  = 10'sd123;
      end
      if (k % 4 == 0 && k / 4 >= NA) bus.in = '0;
      tick();
      acc = 0;
      for (int j = 0; j < NA; j++) begin
        t = k - 11 - 4 * j;
        if (t >= 0 && t <= 6) acc += h[t] * xs[j];
      end
      expr = real'(acc) / 4.0;
      err  = real'(bus.out) - expr;
      n_checks++;
      if (err > 1.0 || err < -1.0) begin
        n_fail++; $display("FAIL full_scale k=%0d: got %0d, expected %f", k, bus.out, expr);
      end
    end
  endtask

  initial begin
    bus.eno = 1'b0;
    bus.in  = '0;
    test_reset();
    test_phase();
    test_impulse(1'b0);
    test_step(100);
    test_step(-512);
    test_gaps();
    test_async_reset();
    test_full_scale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
